fragment_span_generator: RTL and testbench

FRAGMENT_SPAN_GENERATOR -- requirements
Module: fragment_span_generator

---
 rtl/fragment_span_generator.sv | 236 +++++++++++++++++++++++
 tb/tb_fragment_span_generator.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fragment_span_generator.sv
// Walks a triangle bounding box in LANES-wide groups, evaluates three edge
// functions per lane, and queues covered groups in an output FIFO.
module fragment_span_generator #(
  parameter int LANES   = 4,
  parameter int EW      = 32,
  parameter int CW      = 16,
  parameter int LG_FIFO = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                emit_all,
  input  logic [CW-1:0]       xmin,
  input  logic [CW-1:0]       xmax,
  input  logic [CW-1:0]       ymin,
  input  logic [CW-1:0]       ymax,
  input  logic [EW-1:0]       e0_init,
  input  logic [EW-1:0]       e1_init,
  input  logic [EW-1:0]       e2_init,
  input  logic [EW-1:0]       e0_dx,
  input  logic [EW-1:0]       e1_dx,
  input  logic [EW-1:0]       e2_dx,
  input  logic [EW-1:0]       e0_dy,
  input  logic [EW-1:0]       e1_dy,
  input  logic [EW-1:0]       e2_dy,
  input  logic                frag_ready,
  output logic                frag_valid,
  output logic [CW-1:0]       frag_x,
  output logic [CW-1:0]       frag_y,
  output logic [LANES-1:0]    frag_mask,
  output logic [LANES*EW-1:0] frag_w0,
  output logic [LANES*EW-1:0] frag_w1,
  output logic [LANES*EW-1:0] frag_w2,
  output logic                busy,
  output logic                done
);

  localparam int DEPTH = 1 << LG_FIFO;

  typedef enum logic [1:0] {
    IDLE, SETUP, SPAN, DONE
  } state_t;

  state_t state_q, state_d;

  logic          emit_q;
  logic [CW-1:0] xmin_q, xmax_q, ymax_q;
  logic [CW-1:0] x_q, y_q;

  logic [EW-1:0] init_v [3];
  logic [EW-1:0] dx_v   [3];
  logic [EW-1:0] dy_v   [3];
  logic [EW-1:0] dx_q   [3];
  logic [EW-1:0] dy_q   [3];
  logic [EW-1:0] row_q  [3];
  logic [EW-1:0] cur_q  [3];
  logic [EW-1:0] str_q  [3];
  logic [EW-1:0] off_q  [3][LANES];
  logic [EW-1:0] lane_e [3][LANES];

  logic [LANES*EW-1:0] wvec [3];
  logic [LANES-1:0]    mask;

  logic x_fits, empty_box;
  logic full, empty, push, pop, adv;
  logic [LG_FIFO:0] wp_q, rp_q;

  always_comb begin
    init_v[0] = e0_init;
    init_v[1] = e1_init;
    init_v[2] = e2_init;
    dx_v[0]   = e0_dx;
    dx_v[1]   = e1_dx;
    dx_v[2]   = e2_dx;
    dy_v[0]   = e0_dy;
    dy_v[1]   = e1_dy;
    dy_v[2]   = e2_dy;
  end

  // CW+1 bit compares so a box ending at the top coordinate cannot wrap
  assign x_fits = ({1'b0, x_q} + (CW+1)'(LANES))
                  <= {1'b0, xmax_q};
  assign empty_box = (x_q > xmax_q) || (y_q > ymax_q);

  always_comb begin
    mask = '0;
    for (int k = 0; k < 3; k++) begin
      wvec[k] = '0;
      for (int i = 0; i < LANES; i++) begin
        lane_e[k][i] = cur_q[k] + off_q[k][i];
        wvec[k][i*EW +: EW] = lane_e[k][i];
      end
    end
    for (int i = 0; i < LANES; i++) begin
      mask[i] = !lane_e[0][i][EW-1]
             && !lane_e[1][i][EW-1]
             && !lane_e[2][i][EW-1]
             && (({1'b0, x_q} + (CW+1)'(i))
                 <= {1'b0, xmax_q});
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    adv     = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = SETUP;
      SETUP: begin
        if (abort || empty_box) state_d = DONE;
        else                    state_d = SPAN;
      end
      SPAN: begin
        if (abort) begin
          state_d = DONE;
        end else if (!full) begin
          adv  = 1'b1;
          push = emit_q || (mask != '0);
          if (!x_fits && (y_q == ymax_q))
            state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      emit_q <= 1'b0;
      xmin_q <= '0;
      xmax_q <= '0;
      ymax_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      for (int k = 0; k < 3; k++) begin
        dx_q[k]  <= '0;
        dy_q[k]  <= '0;
        row_q[k] <= '0;
        cur_q[k] <= '0;
        str_q[k] <= '0;
        for (int i = 0; i < LANES; i++)
          off_q[k][i] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          emit_q <= emit_all;
          xmin_q <= xmin;
          xmax_q <= xmax;
          ymax_q <= ymax;
          x_q    <= xmin;
          y_q    <= ymin;
          for (int k = 0; k < 3; k++) begin
            dx_q[k]  <= dx_v[k];
            dy_q[k]  <= dy_v[k];
            row_q[k] <= init_v[k];
            cur_q[k] <= init_v[k];
          end
        end
        SETUP: begin
          for (int k = 0; k < 3; k++) begin
            str_q[k] <= EW'(LANES) * dx_q[k];
            for (int i = 0; i < LANES; i++)
              off_q[k][i] <= EW'(i) * dx_q[k];
          end
        end
        SPAN: if (adv) begin
          if (x_fits) begin
            x_q <= x_q + CW'(LANES);
            for (int k = 0; k < 3; k++)
              cur_q[k] <= cur_q[k] + str_q[k];
          end else if (y_q != ymax_q) begin
            x_q <= xmin_q;
            y_q <= y_q + 1'b1;
            for (int k = 0; k < 3; k++) begin
              row_q[k] <= row_q[k] + dy_q[k];
              cur_q[k] <= row_q[k] + dy_q[k];
            end
          end
        end
        default: ;
      endcase
    end
  end

  logic [CW-1:0]       fx_m [DEPTH];
  logic [CW-1:0]       fy_m [DEPTH];
  logic [LANES-1:0]    fm_m [DEPTH];
  logic [LANES*EW-1:0] w0_m [DEPTH];
  logic [LANES*EW-1:0] w1_m [DEPTH];
  logic [LANES*EW-1:0] w2_m [DEPTH];

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[LG_FIFO] != rp_q[LG_FIFO])
              && (wp_q[LG_FIFO-1:0] == rp_q[LG_FIFO-1:0]);
  assign pop   = frag_ready && !empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fx_m[wp_q[LG_FIFO-1:0]] <= x_q;
      fy_m[wp_q[LG_FIFO-1:0]] <= y_q;
      fm_m[wp_q[LG_FIFO-1:0]] <= mask;
      w0_m[wp_q[LG_FIFO-1:0]] <= wvec[0];
      w1_m[wp_q[LG_FIFO-1:0]] <= wvec[1];
      w2_m[wp_q[LG_FIFO-1:0]] <= wvec[2];
    end
  end

  assign frag_valid = !empty;
  assign frag_x     = fx_m[rp_q[LG_FIFO-1:0]];
  assign frag_y     = fy_m[rp_q[LG_FIFO-1:0]];
  assign frag_mask  = fm_m[rp_q[LG_FIFO-1:0]];
  assign frag_w0    = w0_m[rp_q[LG_FIFO-1:0]];
  assign frag_w1    = w1_m[rp_q[LG_FIFO-1:0]];
  assign frag_w2    = w2_m[rp_q[LG_FIFO-1:0]];
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_fragment_span_generator.sv
// Bench for fragment_span_generator: directed table, corner sequences,
// and random triangles against a per-pixel reference model.
module tb_fragment_span_generator;

  localparam int LANES = 4;
  localparam int EW    = 32;
  localparam int CW    = 16;
  localparam int LGF   = 1;

  logic clk = 0;
  logic rst = 0;
  logic start = 0, abort = 0, emit_all = 0;
  logic [CW-1:0] xmin = 0, xmax = 0, ymin = 0, ymax = 0;
  logic [EW-1:0] e0_init = 0, e1_init = 0, e2_init = 0;
  logic [EW-1:0] e0_dx = 0, e1_dx = 0, e2_dx = 0;
  logic [EW-1:0] e0_dy = 0, e1_dy = 0, e2_dy = 0;
  logic frag_ready = 0;
  logic frag_valid, busy, done;
  logic [CW-1:0] frag_x, frag_y;
  logic [LANES-1:0] frag_mask;
  logic [LANES*EW-1:0] frag_w0, frag_w1, frag_w2;

  fragment_span_generator #(
    .LANES(LANES), .EW(EW), .CW(CW), .LG_FIFO(LGF)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .emit_all(emit_all),
    .xmin(xmin), .xmax(xmax), .ymin(ymin), .ymax(ymax),
    .e0_init(e0_init), .e1_init(e1_init), .e2_init(e2_init),
    .e0_dx(e0_dx), .e1_dx(e1_dx), .e2_dx(e2_dx),
    .e0_dy(e0_dy), .e1_dy(e1_dy), .e2_dy(e2_dy),
    .frag_ready(frag_ready), .frag_valid(frag_valid),
    .frag_x(frag_x), .frag_y(frag_y), .frag_mask(frag_mask),
    .frag_w0(frag_w0), .frag_w1(frag_w1), .frag_w2(frag_w2),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0]       x;
    logic [CW-1:0]       y;
    logic [LANES-1:0]    m;
    logic [LANES*EW-1:0] w0;
    logic [LANES*EW-1:0] w1;
    logic [LANES*EW-1:0] w2;
  } grp_t;

  grp_t got_q[$];
  grp_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  // Reference: every LANES-wide group of the box, each lane's edges
  // evaluated directly from the plane equation at that pixel.
  task automatic model();
    grp_t g;
    logic [EW-1:0] a, b, c;
    bit cov;
    exp_q.delete();
    if (xmin > xmax || ymin > ymax) return;
    for (int y = ymin; y <= ymax; y++) begin
      for (int x = xmin; x <= xmax; x += LANES) begin
        g = '0;
        g.x = CW'(x);
        g.y = CW'(y);
        for (int i = 0; i < LANES; i++) begin
          a = e0_init + 32'(x - xmin + i) * e0_dx + 32'(y - ymin) * e0_dy;
          b = e1_init + 32'(x - xmin + i) * e1_dx + 32'(y - ymin) * e1_dy;
          c = e2_init + 32'(x - xmin + i) * e2_dx + 32'(y - ymin) * e2_dy;
          cov = !a[EW-1] && !b[EW-1] && !c[EW-1] && (x + i <= xmax);
          g.m[i] = cov;
          g.w0[i*EW +: EW] = a;
          g.w1[i*EW +: EW] = b;
          g.w2[i*EW +: EW] = c;
        end
        if (emit_all || g.m != 0) exp_q.push_back(g);
      end
    end
  endtask

  task automatic collect(input bit rnd);
    int cyc = 0;
    bit fin = 0;
    got_q.delete();
    done_cnt = 0;
    while (!fin) begin
      frag_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (done) done_cnt++;
      if (frag_valid && frag_ready)
        got_q.push_back({frag_x, frag_y, frag_mask,
                         frag_w0, frag_w1, frag_w2});
      if (!busy && !frag_valid) fin = 1;
      cyc++;
      if (cyc > 3000) begin
        tests++;
        fails++;
        $display("FAIL collect_timeout got=busy%0b exp=idle", busy);
        fin = 1;
      end
      @(posedge clk);
      #1;
    end
    frag_ready = 0;
  endtask

  task automatic cmp_all(input string tag);
    int n;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int j = 0; j < n; j++) begin
      chk($sformatf("%s_g%0d_xy", tag, j),
          {got_q[j].x, got_q[j].y}, {exp_q[j].x, exp_q[j].y});
      chk($sformatf("%s_g%0d_mask", tag, j), got_q[j].m, exp_q[j].m);
      chk($sformatf("%s_g%0d_w0", tag, j), got_q[j].w0, exp_q[j].w0);
      chk($sformatf("%s_g%0d_w1", tag, j), got_q[j].w1, exp_q[j].w1);
      chk($sformatf("%s_g%0d_w2", tag, j), got_q[j].w2, exp_q[j].w2);
    end
  endtask

  typedef struct {
    logic [CW-1:0]  x0, x1, y0, y1;
    logic [EW-1:0]  ei, edx, edy;
    bit             emit;
    int             n;
    logic [CW-1:0]  fx;
    logic [3:0]     fm;
    logic [127:0]   fw;
    logic [CW-1:0]  lx, ly;
    logic [3:0]     lm;
    logic [127:0]   lw;
  } vec_t;

  vec_t vt[8];

  task automatic set_box(input logic [CW-1:0] x0, x1, y0, y1,
                         input logic [EW-1:0] ei, edx, edy,
                         input bit em);
    xmin = x0; xmax = x1; ymin = y0; ymax = y1;
    e0_init = ei; e0_dx = edx; e0_dy = edy;
    e1_init = 0; e1_dx = 1; e1_dy = 1;
    e2_init = 0; e2_dx = 1; e2_dy = 1;
    emit_all = em;
  endtask

  initial begin
    vt[0] = '{0, 7, 0, 1, 0, 1, 1, 0, 4, 0, 4'hF,
              128'h3_00000002_00000001_00000000, 4, 1, 4'hF,
              128'h8_00000007_00000006_00000005};
    vt[1] = '{0, 5, 0, 0, 0, 1, 1, 0, 2, 0, 4'hF,
              128'h3_00000002_00000001_00000000, 4, 0, 4'h3,
              128'h7_00000006_00000005_00000004};
    vt[2] = '{0, 7, 0, 0, -32'sd6, 1, 1, 0, 1, 4, 4'hC,
              128'h1_00000000_FFFFFFFF_FFFFFFFE, 4, 0, 4'hC,
              128'h1_00000000_FFFFFFFF_FFFFFFFE};
    vt[3] = '{0, 7, 0, 0, -32'sd6, 1, 1, 1, 2, 0, 4'h0,
              128'hFFFFFFFD_FFFFFFFC_FFFFFFFB_FFFFFFFA, 4, 0, 4'hC,
              128'h1_00000000_FFFFFFFF_FFFFFFFE};
    vt[4] = '{5, 4, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[5] = '{0, 3, 3, 2, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[6] = '{16'd65533, 16'd65535, 7, 7, 0, 1, 1, 0, 1,
              16'd65533, 4'h7, 128'h3_00000002_00000001_00000000,
              16'd65533, 7, 4'h7, 128'h3_00000002_00000001_00000000};
    vt[7] = '{0, 3, 0, 2, 0, 1, 10, 0, 3, 0, 4'hF,
              128'h3_00000002_00000001_00000000, 0, 2, 4'hF,
              128'h17_00000016_00000015_00000014};

    tick();
    tick();
    chk("rst_valid", frag_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1;
    tick();

    foreach (vt[v]) begin
      set_box(vt[v].x0, vt[v].x1, vt[v].y0, vt[v].y1,
              vt[v].ei, vt[v].edx, vt[v].edy, vt[v].emit);
      pulse_start();
      collect(0);
      chk($sformatf("v%0d_count", v), got_q.size(), vt[v].n);
      chk($sformatf("v%0d_done", v), done_cnt, 1);
      if (got_q.size() > 0 && vt[v].n > 0) begin
        chk($sformatf("v%0d_first", v),
            {got_q[0].x, got_q[0].y, got_q[0].m},
            {vt[v].fx, vt[v].y0, vt[v].fm});
        chk($sformatf("v%0d_fw0", v), got_q[0].w0, vt[v].fw);
        chk($sformatf("v%0d_last", v),
            {got_q[$].x, got_q[$].y, got_q[$].m},
            {vt[v].lx, vt[v].ly, vt[v].lm});
        chk($sformatf("v%0d_lw0", v), got_q[$].w0, vt[v].lw);
      end
    end

    // Latency, backpressure with a 2-deep FIFO, start ignored while busy
    set_box(0, 7, 0, 3, 0, 1, 1, 0);
    model();
    pulse_start();
    chk("lat_c1_busy", busy, 1);
    chk("lat_c1_valid", frag_valid, 0);
    tick();
    chk("lat_c2_valid", frag_valid, 0);
    tick();
    chk("lat_c3_valid", frag_valid, 1);
    set_box(2, 3, 5, 5, -32'sd100, 0, 0, 1);
    pulse_start();
    for (int c = 0; c < 8; c++) tick();
    chk("stall_busy", busy, 1);
    chk("stall_done", done, 0);
    chk("stall_head", {frag_x, frag_y}, {16'd0, 16'd0});
    collect(0);
    cmp_all("stall");

    // Empty box: done at cycle 2, nothing queued
    set_box(5, 4, 0, 0, 0, 1, 1, 1);
    pulse_start();
    chk("empty_c1_done", done, 0);
    tick();
    chk("empty_c2_done", done, 1);
    chk("empty_c2_valid", frag_valid, 0);
    tick();
    chk("empty_c3_done", done, 0);
    chk("empty_c3_busy", busy, 0);

    // Abort mid-run keeps what is already queued
    set_box(0, 7, 0, 15, 0, 1, 1, 0);
    model();
    while (exp_q.size() > 2) void'(exp_q.pop_back());
    pulse_start();
    tick();
    tick();
    tick();
    abort = 1;
    tick();
    abort = 0;
    chk("abort_done", done, 1);
    collect(0);
    cmp_all("abort");

    // Reset in the middle of a traversal
    set_box(0, 7, 0, 15, 0, 1, 1, 1);
    pulse_start();
    tick();
    tick();
    tick();
    rst = 0;
    tick();
    chk("mrst_valid", frag_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    rst = 1;
    tick();

    for (int r = 0; r < 30; r++) begin
      int x0, y0;
      x0 = (r % 7 == 3) ? 65528 : int'($urandom_range(0, 20));
      y0 = $urandom_range(0, 100);
      xmin = CW'(x0);
      xmax = (x0 + int'($urandom_range(0, 10)) > 65535) ? 16'hFFFF :
             CW'(x0 + int'($urandom_range(0, 10)));
      ymin = CW'(y0);
      ymax = CW'(y0 + int'($urandom_range(0, 2)));
      if (r % 9 == 8) xmax = xmin - 1;
      if (r % 5 == 4) begin
        e0_init = $urandom; e1_init = $urandom; e2_init = $urandom;
        e0_dx = $urandom; e1_dx = $urandom; e2_dx = $urandom;
        e0_dy = $urandom; e1_dy = $urandom; e2_dy = $urandom;
      end else begin
        e0_init = EW'(int'($urandom_range(0, 80)) - 40);
        e1_init = EW'(int'($urandom_range(0, 80)) - 20);
        e2_init = EW'(int'($urandom_range(0, 80)) - 20);
        e0_dx = EW'(int'($urandom_range(0, 10)) - 5);
        e1_dx = EW'(int'($urandom_range(0, 10)) - 5);
        e2_dx = EW'(int'($urandom_range(0, 10)) - 5);
        e0_dy = EW'(int'($urandom_range(0, 10)) - 5);
        e1_dy = EW'(int'($urandom_range(0, 10)) - 5);
        e2_dy = EW'(int'($urandom_range(0, 10)) - 5);
      end
      emit_all = 1'($urandom_range(0, 1));
      model();
      pulse_start();
      collect(1);
      cmp_all($sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d_done", r), done_cnt, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
